// File: rtl/crc_d8_frame_chk.sv
// Receive-side CRC-8 (poly 0x07) frame checker: strips the trailer byte,
// forwards the payload and reports one status pulse per frame.
module crc_d8_frame_chk #(
    parameter int unsigned MAX_LEN = 255,
    parameter int unsigned LEN_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic [7:0]       m_data,
    output logic             m_valid,
    output logic             m_last,
    output logic             frame_done,
    output logic             frame_ok,
    output logic             err_crc,
    output logic             err_len,
    output logic [LEN_W-1:0] frame_len
);

    typedef enum logic [1:0] {IDLE, RECV, DISCARD} state_t;

    state_t           state_q, state_d;
    logic [7:0]       hold_q, hold_d;
    logic [7:0]       crc_q, crc_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [7:0]       m_data_q, m_data_d;
    logic             m_valid_q, m_valid_d;
    logic             m_last_q, m_last_d;
    logic             frame_done_q, frame_done_d;
    logic             frame_ok_q, frame_ok_d;
    logic             err_crc_q, err_crc_d;
    logic             err_len_q, err_len_d;
    logic [LEN_W-1:0] frame_len_q, frame_len_d;

    logic [LEN_W-1:0] cnt_inc;
    logic             at_max;
    logic [7:0]       crc_upd;

    // Parallel CRC-8 step: (c ^ d) shifted 8 times through poly 0x07
    function automatic logic [7:0] crc_next(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] x;
        x = c ^ d;
        for (int i = 0; i < 8; i++) begin
            x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
        end
        return x;
    endfunction

    assign cnt_inc = cnt_q + LEN_W'(1);
    assign at_max  = (cnt_inc == LEN_W'(MAX_LEN));
    assign crc_upd = crc_next(crc_q, hold_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            hold_q       <= 8'h00;
            crc_q        <= 8'h00;
            cnt_q        <= '0;
            m_data_q     <= 8'h00;
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
            frame_done_q <= 1'b0;
            frame_ok_q   <= 1'b0;
            err_crc_q    <= 1'b0;
            err_len_q    <= 1'b0;
            frame_len_q  <= '0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            crc_q        <= crc_d;
            cnt_q        <= cnt_d;
            m_data_q     <= m_data_d;
            m_valid_q    <= m_valid_d;
            m_last_q     <= m_last_d;
            frame_done_q <= frame_done_d;
            frame_ok_q   <= frame_ok_d;
            err_crc_q    <= err_crc_d;
            err_len_q    <= err_len_d;
            frame_len_q  <= frame_len_d;
        end
    end

    // Next state: hold register delays payload so the trailer never leaves
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        crc_d   = crc_q;
        cnt_d   = cnt_q;
        if (s_valid) begin
            case (state_q)
                IDLE: begin
                    if (!s_last) begin
                        hold_d  = s_data;
                        crc_d   = 8'h00;
                        cnt_d   = '0;
                        state_d = RECV;
                    end
                end
                RECV: begin
                    if (s_last) begin
                        state_d = IDLE;
                    end else if (at_max) begin
                        state_d = DISCARD;
                    end else begin
                        crc_d  = crc_upd;
                        hold_d = s_data;
                        cnt_d  = cnt_inc;
                    end
                end
                DISCARD: begin
                    if (s_last) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output strobes and frame status
    always_comb begin
        m_data_d     = 8'h00;
        m_valid_d    = 1'b0;
        m_last_d     = 1'b0;
        frame_done_d = 1'b0;
        frame_ok_d   = 1'b0;
        err_crc_d    = 1'b0;
        err_len_d    = 1'b0;
        frame_len_d  = '0;
        if (s_valid) begin
            case (state_q)
                IDLE: begin
                    if (s_last) begin
                        frame_done_d = 1'b1;
                        err_len_d    = 1'b1;
                    end
                end
                RECV: begin
                    m_valid_d = 1'b1;
                    m_data_d  = hold_q;
                    if (s_last) begin
                        m_last_d     = 1'b1;
                        frame_done_d = 1'b1;
                        frame_len_d  = cnt_inc;
                        frame_ok_d   = (crc_upd == s_data);
                        err_crc_d    = (crc_upd != s_data);
                    end else if (at_max) begin
                        m_last_d = 1'b1;
                    end
                end
                DISCARD: begin
                    if (s_last) begin
                        frame_done_d = 1'b1;
                        err_len_d    = 1'b1;
                        frame_len_d  = LEN_W'(MAX_LEN);
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_data     = m_data_q;
    assign m_valid    = m_valid_q;
    assign m_last     = m_last_q;
    assign frame_done = frame_done_q;
    assign frame_ok   = frame_ok_q;
    assign err_crc    = err_crc_q;
    assign err_len    = err_len_q;
    assign frame_len  = frame_len_q;

endmodule

// File: tb/tb_crc_d8_frame_chk.sv
// Bench for crc_d8_frame_chk: directed scenarios plus random frames scored
// against a bit-serial CRC model, on a default and a MAX_LEN=4 instance.
module tb_crc_d8_frame_chk;

    localparam int unsigned MAXB = 4;

    typedef struct packed {
        logic       ok;
        logic       ecrc;
        logic       elen;
        logic [7:0] len;
        logic       mlast;
    } st_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_last = 1'b0;

    logic [7:0] a_m_data, b_m_data;
    logic       a_m_valid, a_m_last, a_done, a_ok, a_ecrc, a_elen;
    logic       b_m_valid, b_m_last, b_done, b_ok, b_ecrc, b_elen;
    logic [7:0] a_len, b_len;

    int total = 0;
    int bad   = 0;
    int stray_a = 0;
    int stray_b = 0;

    logic [8:0] got_a[$], got_b[$], exp_a[$], exp_b[$];
    st_t        sts_a[$], sts_b[$], exps_a[$], exps_b[$];

    crc_d8_frame_chk dut_a (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .m_data(a_m_data), .m_valid(a_m_valid), .m_last(a_m_last), .frame_done(a_done),
        .frame_ok(a_ok), .err_crc(a_ecrc), .err_len(a_elen), .frame_len(a_len)
    );

    crc_d8_frame_chk #(.MAX_LEN(MAXB)) dut_b (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .m_data(b_m_data), .m_valid(b_m_valid), .m_last(b_m_last), .frame_done(b_done),
        .frame_ok(b_ok), .err_crc(b_ecrc), .err_len(b_elen), .frame_len(b_len)
    );

    always #5 clk = ~clk;

    // Collect output traffic away from the active edge
    always @(negedge clk) begin
        if (a_m_valid) got_a.push_back({a_m_last, a_m_data});
        if (a_done) sts_a.push_back({a_ok, a_ecrc, a_elen, a_len, a_m_last});
        if (!a_done && (a_ok || a_ecrc || a_elen || a_len != 8'h00)) stray_a = stray_a + 1;
        if (a_m_last && !a_m_valid) stray_a = stray_a + 1;
        if (b_m_valid) got_b.push_back({b_m_last, b_m_data});
        if (b_done) sts_b.push_back({b_ok, b_ecrc, b_elen, b_len, b_m_last});
        if (!b_done && (b_ok || b_ecrc || b_elen || b_len != 8'h00)) stray_b = stray_b + 1;
        if (b_m_last && !b_m_valid) stray_b = stray_b + 1;
    end

    function automatic st_t mk_st(input logic ok, input logic ec, input logic el,
                                  input logic [7:0] len, input logic ml);
        return {ok, ec, el, len, ml};
    endfunction

    // Reference CRC: bit-serial LFSR, message MSB first
    function automatic logic [7:0] crc_ser(input logic [7:0] fr[$], input int n);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 0; i < n; i++) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[7] ^ fr[i][b];
                c  = {c[6:0], 1'b0};
                if (fb) c = c ^ 8'h07;
            end
        end
        return c;
    endfunction

    // Frame-level model: payload is all but the trailer, truncated at mx
    task automatic model(input logic [7:0] fr[$], input int mx, input bit to_a);
        int   plen;
        int   fw;
        logic ok;
        st_t  st;
        plen = fr.size() - 1;
        fw   = (plen > mx) ? mx : plen;
        for (int i = 0; i < fw; i++) begin
            if (to_a) exp_a.push_back({i == fw - 1, fr[i]});
            else      exp_b.push_back({i == fw - 1, fr[i]});
        end
        if (plen == 0) begin
            st = mk_st(1'b0, 1'b0, 1'b1, 8'd0, 1'b0);
        end else if (plen > mx) begin
            st = mk_st(1'b0, 1'b0, 1'b1, 8'(mx), 1'b0);
        end else begin
            ok = (crc_ser(fr, plen) == fr[plen]);
            st = mk_st(ok, !ok, 1'b0, 8'(plen), 1'b1);
        end
        if (to_a) exps_a.push_back(st);
        else      exps_b.push_back(st);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] d, input logic l);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        cyc();
        s_valid = 1'b0;
        s_last  = 1'($urandom_range(0, 1));
        s_data  = 8'($urandom);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            s_last = 1'($urandom_range(0, 1));
            s_data = 8'($urandom);
            cyc();
        end
    endtask

    task automatic send(input logic [7:0] fr[$], input int maxgap);
        for (int i = 0; i < fr.size(); i++) begin
            put(fr[i], i == fr.size() - 1);
            if (i != fr.size() - 1) gap($urandom_range(0, maxgap));
        end
    endtask

    task automatic clr();
        got_a.delete(); got_b.delete(); sts_a.delete(); sts_b.delete();
        exp_a.delete(); exp_b.delete(); exps_a.delete(); exps_b.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        total++;
        if ({a_m_data, a_m_valid, a_m_last, a_done, a_ok, a_ecrc, a_elen, a_len} !== 22'd0) begin
            bad++;
            $display("FAIL reset_a outputs=%h exp=0",
                     {a_m_data, a_m_valid, a_m_last, a_done, a_ok, a_ecrc, a_elen, a_len});
        end
        total++;
        if ({b_m_data, b_m_valid, b_m_last, b_done, b_ok, b_ecrc, b_elen, b_len} !== 22'd0) begin
            bad++;
            $display("FAIL reset_b outputs=%h exp=0",
                     {b_m_data, b_m_valid, b_m_last, b_done, b_ok, b_ecrc, b_elen, b_len});
        end
        rst_n = 1'b1;
        cyc();
        clr();
        stray_a = 0;
        stray_b = 0;
    endtask

    task automatic test_crc(input logic [7:0] trailer, input st_t exp_st);
        logic [8:0] e;
        clr();
        for (int i = 0; i < 9; i++) begin
            put(8'(8'h31 + i), 1'b0);
            if (i == 3 || i == 6) gap(1);
        end
        put(trailer, 1'b1);
        gap(3);
        total++;
        if (got_a.size() !== 9) begin
            bad++;
            $display("FAIL crc_%h_count got=%0d exp=9", trailer, got_a.size());
        end
        for (int i = 0; i < got_a.size() && i < 9; i++) begin
            e = {i == 8, 8'(8'h31 + i)};
            total++;
            if (got_a[i] !== e) begin
                bad++;
                $display("FAIL crc_%h_byte%0d got=%h exp=%h", trailer, i, got_a[i], e);
            end
        end
        total++;
        if (sts_a.size() !== 1) begin
            bad++;
            $display("FAIL crc_%h_done_count got=%0d exp=1", trailer, sts_a.size());
        end else begin
            total++;
            if (sts_a[0] !== exp_st) begin
                bad++;
                $display("FAIL crc_%h_status got=%h exp=%h", trailer, sts_a[0], exp_st);
            end
        end
    endtask

    task automatic test_back_to_back();
        st_t s;
        clr();
        put(8'h01, 1'b0); put(8'h07, 1'b1);
        put(8'h00, 1'b0); put(8'h00, 1'b1);
        gap(3);
        s = mk_st(1'b1, 1'b0, 1'b0, 8'd1, 1'b1);
        total++;
        if (got_a.size() !== 2 || got_a[0] !== 9'h101 || got_a[1] !== 9'h100) begin
            bad++;
            $display("FAIL b2b_data got=%p exp=101,100", got_a);
        end
        total++;
        if (sts_a.size() !== 2 || sts_a[0] !== s || sts_a[1] !== s) begin
            bad++;
            $display("FAIL b2b_status got=%p exp=2x%h", sts_a, s);
        end
    endtask

    task automatic test_short();
        st_t s;
        clr();
        put(8'h00, 1'b1);
        gap(3);
        s = mk_st(1'b0, 1'b0, 1'b1, 8'd0, 1'b0);
        total++;
        if (got_a.size() !== 0 || got_b.size() !== 0) begin
            bad++;
            $display("FAIL short_mvalid got=%0d/%0d exp=0", got_a.size(), got_b.size());
        end
        total++;
        if (sts_a.size() !== 1 || sts_a[0] !== s) begin
            bad++;
            $display("FAIL short_status got=%p exp=%h", sts_a, s);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] fr[$];
        st_t        s;
        clr();
        for (int i = 0; i < 7; i++) fr.push_back(8'(8'h10 + i));
        send(fr, 1);
        gap(3);
        s = mk_st(1'b0, 1'b0, 1'b1, 8'd4, 1'b0);
        total++;
        if (got_b.size() !== 4) begin
            bad++;
            $display("FAIL ovf_count got=%0d exp=4", got_b.size());
        end
        for (int i = 0; i < got_b.size() && i < 4; i++) begin
            total++;
            if (got_b[i] !== {i == 3, 8'(8'h10 + i)}) begin
                bad++;
                $display("FAIL ovf_byte%0d got=%h exp=%h", i, got_b[i], {i == 3, 8'(8'h10 + i)});
            end
        end
        total++;
        if (sts_b.size() !== 1 || sts_b[0] !== s) begin
            bad++;
            $display("FAIL ovf_status got=%p exp=%h", sts_b, s);
        end
    endtask

    task automatic test_abort();
        st_t s;
        clr();
        put(8'hAA, 1'b0); put(8'hBB, 1'b0); put(8'hCC, 1'b0);
        rst_n = 1'b0;
        cyc();
        total++;
        if ({a_m_valid, a_done, a_m_data} !== 10'd0) begin
            bad++;
            $display("FAIL abort_reset_out got=%h exp=0", {a_m_valid, a_done, a_m_data});
        end
        total++;
        if (got_a.size() !== 2 || got_a[0] !== 9'h0AA || got_a[1] !== 9'h0BB || sts_a.size() !== 0) begin
            bad++;
            $display("FAIL abort_pre got=%p done=%0d exp=0aa,0bb done=0", got_a, sts_a.size());
        end
        rst_n = 1'b1;
        clr();
        put(8'h01, 1'b0); put(8'h07, 1'b1);
        gap(3);
        s = mk_st(1'b1, 1'b0, 1'b0, 8'd1, 1'b1);
        total++;
        if (got_a.size() !== 1 || got_a[0] !== 9'h101) begin
            bad++;
            $display("FAIL abort_data got=%p exp=101", got_a);
        end
        total++;
        if (sts_a.size() !== 1 || sts_a[0] !== s) begin
            bad++;
            $display("FAIL abort_status got=%p exp=%h", sts_a, s);
        end
    endtask

    task automatic test_random();
        logic [7:0] fr[$];
        int         n;
        clr();
        stray_a = 0;
        stray_b = 0;
        for (int f = 0; f < 41; f++) begin
            fr.delete();
            n = (f == 40) ? 255 : $urandom_range(0, 11);
            for (int i = 0; i < n; i++) fr.push_back(8'($urandom));
            fr.push_back($urandom_range(0, 1) ? crc_ser(fr, n) : 8'($urandom));
            model(fr, 255, 1'b1);
            model(fr, MAXB, 1'b0);
            send(fr, 2);
            gap($urandom_range(0, 2));
        end
        gap(3);
        total++;
        if (got_a.size() !== exp_a.size() || sts_a.size() !== exps_a.size()) begin
            bad++;
            $display("FAIL rnd_a_counts got=%0d/%0d exp=%0d/%0d",
                     got_a.size(), sts_a.size(), exp_a.size(), exps_a.size());
        end
        total++;
        if (got_b.size() !== exp_b.size() || sts_b.size() !== exps_b.size()) begin
            bad++;
            $display("FAIL rnd_b_counts got=%0d/%0d exp=%0d/%0d",
                     got_b.size(), sts_b.size(), exp_b.size(), exps_b.size());
        end
        for (int i = 0; i < got_a.size() && i < exp_a.size(); i++) begin
            total++;
            if (got_a[i] !== exp_a[i]) begin
                bad++;
                $display("FAIL rnd_a_byte%0d got=%h exp=%h", i, got_a[i], exp_a[i]);
            end
        end
        for (int i = 0; i < got_b.size() && i < exp_b.size(); i++) begin
            total++;
            if (got_b[i] !== exp_b[i]) begin
                bad++;
                $display("FAIL rnd_b_byte%0d got=%h exp=%h", i, got_b[i], exp_b[i]);
            end
        end
        for (int i = 0; i < sts_a.size() && i < exps_a.size(); i++) begin
            total++;
            if (sts_a[i] !== exps_a[i]) begin
                bad++;
                $display("FAIL rnd_a_status%0d got=%h exp=%h", i, sts_a[i], exps_a[i]);
            end
        end
        for (int i = 0; i < sts_b.size() && i < exps_b.size(); i++) begin
            total++;
            if (sts_b[i] !== exps_b[i]) begin
                bad++;
                $display("FAIL rnd_b_status%0d got=%h exp=%h", i, sts_b[i], exps_b[i]);
            end
        end
        total++;
        if (stray_a !== 0 || stray_b !== 0) begin
            bad++;
            $display("FAIL stray_outputs got=%0d/%0d exp=0/0", stray_a, stray_b);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_crc(8'hF4, mk_st(1'b1, 1'b0, 1'b0, 8'd9, 1'b1));
        test_crc(8'hF5, mk_st(1'b0, 1'b1, 1'b0, 8'd9, 1'b1));
        test_back_to_back();
        test_short();
        test_overflow();
        test_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
